logic_op_arbiter: RTL and testbench
===================================

Name: logic_op_arbiter

Overview:
- Shares one bitwise logic unit (AND, NAND, OR, NOR, XOR, XNOR, NOT) among NREQ requesters using round-robin arbitration.
- Each requester issues an opcode and two operands over a valid/ready handshake.
- The block grants one requester per cycle, computes the result into a single output register and returns it with the requester ID over a valid/ready response channel.
- It sits between requesting control blocks and the shared combinational gate datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i presents a request.
- req_ready  output  NREQ  bit i: request i accepted this cycle (one-hot or zero).
- req_op  input  3*NREQ  opcode of requester i at bits [3i+2:3i].
- req_a  input  WIDTH*NREQ  operand A of requester i at slice i.
- req_b  input  WIDTH*NREQ  operand B of requester i at slice i.
- rsp_valid  output  1  result register holds a valid response.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  computed result.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_err  output  1  opcode was reserved (7).
- grant_cnt  output  16  accepted-request counter (optional feature).
- err_cnt  output  8  reserved-opcode counter (optional feature).

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, req_ready=0, rr_ptr=0, state=IDLE, counters=0.
- States:
  - IDLE: result register empty.
  - HOLD: result register full, waiting for rsp_ready.
- can_accept = (state==IDLE) | (state==HOLD & rsp_ready). This allows one result per cycle when the consumer always accepts.
- Arbitration (combinational): search req_valid starting at rr_ptr, wrapping modulo NREQ. The first set bit is the winner g.
  - req_ready[g] = can_accept. All other bits are 0.
  - No valid request gives req_ready=0.
- Accept edge (req_valid[g] & req_ready[g]):
  - rsp_data <= f(op_g, a_g, b_g); rsp_id <= g; rsp_err <= (op_g==7); rsp_valid <= 1; state <= HOLD.
  - rr_ptr <= (g+1) mod NREQ.
- Opcodes:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR: bitwise on a and b.
  - 6 NOT: ~a, b ignored.
  - 7 reserved: result 0, rsp_err=1.
- Latency: accept at edge N gives rsp_valid=1 after edge N, i.e. one cycle.
- Response drain:
  - HOLD & rsp_ready & no new accept: rsp_valid <= 0, state <= IDLE.
  - HOLD & rsp_ready & new accept: register reloads, rsp_valid stays 1.
- Backpressure: HOLD & !rsp_ready gives req_ready=0. rsp_data, rsp_id and rsp_err hold stable. rr_ptr does not move.
- A requester deasserting req_valid before acceptance is legal. Arbitration re-evaluates every cycle with no lock.
- All requesters valid: grants follow strict rotation 0,1,2,3,0,...
- Single requester k continuously valid: granted every accepting cycle. rr_ptr advances to k+1, and the search wraps back to k.
- Reset asserted mid-HOLD: pending response is discarded, all state returns to reset values.

Optional Feature:
- Macro LOGIC_ARB_STATS_EN.
- Defined:
  - grant_cnt increments on every accept, wrapping at 16 bits.
  - err_cnt increments on every accept with op==7, saturating at 255.
  - Both clear on reset.
- Undefined: grant_cnt and err_cnt are tied to 0 and no counter registers are built.

Test Plan:
- Reset with req_valid=4'b1111 held, then release → req_ready=0 and rsp_valid=0 while reset is high. First grant after release goes to requester 0.
- Requester 2 op=4, a=8'hF0, b=8'h3C, rsp_ready=1 → one cycle later rsp_valid=1, rsp_data=8'hCC, rsp_id=2, rsp_err=0.
- All four valid with ops 0/1/2/3, a=8'hAA, b=8'h0F, rsp_ready=1 → one response per cycle:
  - id 0: 8'h0A
  - id 1: 8'hF5
  - id 2: 8'hAF
  - id 3: 8'h50
- rsp_ready=0 for 3 cycles with all requesters valid → req_ready=0 and rsp_data/rsp_id stable. On rsp_ready=1, the next requester in rotation is granted the same cycle.
- Requester 1 op=6, a=8'h5A → rsp_data=8'hA5. Then op=7 → rsp_data=0, rsp_err=1; with LOGIC_ARB_STATS_EN, grant_cnt=2 and err_cnt=1.
- Assert reset while rsp_valid=1 → rsp_valid=0 immediately (asynchronously). After release, rr_ptr=0.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters.
// Optional request/error statistics counters are built under LOGIC_ARB_STATS_EN.
module logic_op_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err,
    output logic [15:0]           grant_cnt,
    output logic [7:0]            err_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW:0]   sum;
    logic           found;
    logic           can_accept;
    logic           accept;

    logic [2:0]       op_arr [NREQ];
    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];
    logic [2:0]       op_g;
    logic [WIDTH-1:0] a_g;
    logic [WIDTH-1:0] b_g;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign op_arr[gi] = req_op[3*gi +: 3];
        assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
        assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
    end

    function automatic logic [WIDTH-1:0] alu(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        unique case (op)
            3'd0:    r = a & b;
            3'd1:    r = ~(a & b);
            3'd2:    r = a | b;
            3'd3:    r = ~(a | b);
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Search starts at rr_ptr and wraps modulo NREQ; first valid bit wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                grant = sum[IDW-1:0];
            end
        end
    end

    assign can_accept = (state == IDLE) || rsp_ready;
    assign accept     = found && can_accept && !reset;
    assign op_g       = op_arr[grant];
    assign a_g        = a_arr[grant];
    assign b_g        = b_arr[grant];

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            rr_ptr    <= '0;
        end else if (accept) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
            rsp_data  <= alu(op_g, a_g, b_g);
            rsp_id    <= grant;
            rsp_err   <= (op_g == 3'd7);
            rr_ptr    <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
        end else if (state == HOLD && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] gcnt;
    logic [7:0]  ecnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt <= '0;
            ecnt <= '0;
        end else if (accept) begin
            gcnt <= gcnt + 16'd1;
            if (op_g == 3'd7 && ecnt != 8'hFF)
                ecnt <= ecnt + 8'd1;
        end
    end

    assign grant_cnt = gcnt;
    assign err_cnt   = ecnt;
`else
    assign grant_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter: reference arbitration model,
// expected-response queue, directed scenarios and a random soak.
module tb_logic_op_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    typedef struct {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
        logic             err;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_err;
    logic [15:0]           grant_cnt;
    logic [7:0]            err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    rsp_t exp_q [$];
    rsp_t seen  [$];
    int   m_ptr  = 0;
    int   m_gcnt = 0;
    int   m_ecnt = 0;

    logic [7:0] rot [4] = '{8'h0A, 8'hF5, 8'hAF, 8'h50};

    logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_id(rsp_id),
        .rsp_err(rsp_err),
        .grant_cnt(grant_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int winner(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (v[(ptr + i) % NREQ])
                return (ptr + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        int g;
        logic [NREQ-1:0] r;
        r = '0;
        g = winner(req_valid, m_ptr);
        if (!reset && g >= 0 && (exp_q.size() == 0 || rsp_ready))
            r[g] = 1'b1;
        return r;
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clk or posedge reset) begin
        int   g;
        logic hold;
        rsp_t e;
        if (reset) begin
            exp_q.delete();
            m_ptr  = 0;
            m_gcnt = 0;
            m_ecnt = 0;
        end else begin
            hold = (exp_q.size() != 0);
            g    = winner(req_valid, m_ptr);
            if (hold && rsp_ready)
                void'(exp_q.pop_front());
            if (g >= 0 && (!hold || rsp_ready)) begin
                e.id   = IDW'(g);
                e.data = ref_op(req_op[3*g +: 3], req_a[8*g +: 8],
                                req_b[8*g +: 8]);
                e.err  = (req_op[3*g +: 3] == 3'd7);
                exp_q.push_back(e);
                m_ptr  = (g + 1) % NREQ;
                m_gcnt = (m_gcnt + 1) % 65536;
                if (e.err && m_ecnt < 255)
                    m_ecnt++;
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        chk("req_ready", req_ready, model_ready());
        chk("rsp_valid", rsp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("rsp_data", rsp_data, exp_q[0].data);
            chk("rsp_id", rsp_id, exp_q[0].id);
            chk("rsp_err", rsp_err, exp_q[0].err);
        end
`ifdef LOGIC_ARB_STATS_EN
        chk("grant_cnt", grant_cnt, m_gcnt);
        chk("err_cnt", err_cnt, m_ecnt);
`else
        chk("grant_cnt", grant_cnt, 0);
        chk("err_cnt", err_cnt, 0);
`endif
        if (rsp_valid && rsp_ready && !reset) begin
            e.id   = rsp_id;
            e.data = rsp_data;
            e.err  = rsp_err;
            seen.push_back(e);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 3'(i), 8'hAA, 8'h0F);

        // Reset held with all requesters valid, then full rotation
        cyc(3);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        seen.delete();
        cyc(4);
        req_valid = '0;
        cyc(2);
        chk("rot_count", seen.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < seen.size()) begin
                chk("rot_id", seen[k].id, k);
                chk("rot_data", seen[k].data, rot[k]);
            end

        // Single XOR request from requester 2
        seen.delete();
        set_req(2, 3'd4, 8'hF0, 8'h3C);
        req_valid = 4'b0100;
        cyc(1);
        req_valid = '0;
        cyc(2);
        chk("xor_count", seen.size(), 1);
        if (seen.size() > 0) begin
            chk("xor_id", seen[0].id, 2);
            chk("xor_data", seen[0].data, 8'hCC);
            chk("xor_err", seen[0].err, 0);
        end

        // Backpressure with all requesters valid
        set_req(2, 3'd2, 8'hAA, 8'h0F);
        req_valid = '1;
        cyc(1);
        rsp_ready = 1'b0;
        repeat (3) begin
            cyc(1);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_id", rsp_id, 3);
            chk("bp_rsp_data", rsp_data, 8'h50);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", req_ready, 4'b0001);
        cyc(1);
        req_valid = '0;
        cyc(2);

        // Asynchronous reset while a response is pending
        set_req(1, 3'd0, 8'hFF, 8'h11);
        req_valid = 4'b0010;
        cyc(1);
        rsp_ready = 1'b0;
        req_valid = '0;
        #2;
        chk("pre_rst_valid", rsp_valid, 1);
        reset = 1'b1;
        #1;
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_rsp_data", rsp_data, 0);
        chk("async_req_ready", req_ready, 0);
        cyc(2);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        chk("ptr_after_rst", req_ready, 4'b0001);
        set_req(1, 3'd6, 8'h5A, 8'hFF);
        req_valid = 4'b0010;

        // NOT then reserved opcode on requester 1
        seen.delete();
        cyc(1);
        set_req(1, 3'd7, 8'h5A, 8'hFF);
        cyc(1);
        req_valid = '0;
        cyc(2);
        chk("op_count", seen.size(), 2);
        if (seen.size() > 1) begin
            chk("not_data", seen[0].data, 8'hA5);
            chk("not_err", seen[0].err, 0);
            chk("rsv_data", seen[1].data, 8'h00);
            chk("rsv_err", seen[1].err, 1);
            chk("rsv_id", seen[1].id, 1);
        end
`ifdef LOGIC_ARB_STATS_EN
        chk("stat_grant", grant_cnt, 2);
        chk("stat_err", err_cnt, 1);
`else
        chk("stat_grant_off", grant_cnt, 0);
`endif

        // Random soak checked by the scoreboard
        repeat (300) begin
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++)
                set_req(i, 3'($urandom), 8'($urandom), 8'($urandom));
            cyc(1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc(3);
        chk("drain_valid", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
